// File: rtl/seg7_scan_decoder.sv
// Readback decoder for a multiplexed 7-segment bus: waits for each glyph to settle,
// decodes it to hex and reassembles the displayed word frame by frame.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel_n,
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] word_out,
    output logic                    word_valid,
    output logic                    digit_err,
    output logic [NUM_DIGITS-1:0]   err_mask
);

    localparam int BW = NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES);

    logic [BW-1:0]           sync1_q, s_q, p_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    committed_q, committed_d;
    logic [4*NUM_DIGITS-1:0] stage_q, stage_d;
    logic [4*NUM_DIGITS-1:0] word_q, word_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [NUM_DIGITS-1:0]   bad_q, bad_d;
    logic                    valid_q, valid_d;
    logic                    derr_q, derr_d;

    logic                    same, onehot, commit, done;
    logic [NUM_DIGITS-1:0]   sel;
    logic [4:0]              dec;

    // Returns {hit, nibble}; hit=0 for any pattern outside the hex font.
    function automatic logic [4:0] decode(input logic [6:0] g);
        logic [4:0] r;
        case (g)
            7'b1000000: r = 5'h10;
            7'b1111001: r = 5'h11;
            7'b0100100: r = 5'h12;
            7'b0110000: r = 5'h13;
            7'b0011001: r = 5'h14;
            7'b0010010: r = 5'h15;
            7'b0000010: r = 5'h16;
            7'b1111000: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0010000: r = 5'h19;
            7'b0001000: r = 5'h1A;
            7'b0000011: r = 5'h1B;
            7'b1000110: r = 5'h1C;
            7'b0100001: r = 5'h1D;
            7'b0000110: r = 5'h1E;
            7'b0001110: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        same   = (s_q == p_q);
        sel    = ~s_q[BW-1:7];
        onehot = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
        dec    = decode(s_q[6:0]);
        done   = &seen_q;
        commit = same && !committed_q
                 && (cnt_q == CW'(STABLE_CYCLES - 2));

        cnt_d       = cnt_q;
        committed_d = committed_q | commit;
        if (!same) begin
            cnt_d       = '0;
            committed_d = 1'b0;
        end else if (cnt_q != CW'(STABLE_CYCLES - 1)) begin
            cnt_d = cnt_q + CW'(1);
        end

        word_d  = done ? stage_q : word_q;
        valid_d = done;
        seen_d  = done ? '0 : seen_q;
        stage_d = stage_q;
        bad_d   = '0;
        if (commit && onehot) begin
            if (dec[4]) begin
                seen_d = seen_d | sel;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel[i]) stage_d[4*i +: 4] = dec[3:0];
                end
            end else begin
                bad_d = sel;
            end
        end

        // A flag raised in the same cycle as a clear survives it.
        derr_d = |bad_q;
        mask_d = (err_clr ? '0 : mask_q) | bad_q;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sync1_q     <= '1;
            s_q         <= '1;
            p_q         <= '1;
            cnt_q       <= '0;
            committed_q <= 1'b0;
            stage_q     <= '0;
            word_q      <= '0;
            seen_q      <= '0;
            mask_q      <= '0;
            bad_q       <= '0;
            valid_q     <= 1'b0;
            derr_q      <= 1'b0;
        end else begin
            sync1_q     <= {dig_sel_n, seg_in};
            s_q         <= sync1_q;
            p_q         <= s_q;
            cnt_q       <= cnt_d;
            committed_q <= committed_d;
            stage_q     <= stage_d;
            word_q      <= word_d;
            seen_q      <= seen_d;
            mask_q      <= mask_d;
            bad_q       <= bad_d;
            valid_q     <= valid_d;
            derr_q      <= derr_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign digit_err  = derr_q;
    assign err_mask   = mask_q;

endmodule
